// File: rtl/activation_unit_pipe.sv
// activation_unit_pipe: 2-stage valid/ready float activation over NUM_CH lanes with a modified-lane counter
module activation_unit_pipe #(
  parameter int          NUM_CH     = 32,
  parameter int          LEAK_SHIFT = 3,
  parameter logic [31:0] CLAMP_VAL  = 32'h40C00000,
  parameter int          CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*NUM_CH-1:0]  input_fc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NUM_CH-1:0]  output_fc,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      mod_count
);
  localparam int PW = $clog2(NUM_CH + 1);
  localparam logic [32:0] CNT_MAX = (33'd1 << CNT_W) - 33'd1;

  logic                 advance, v1;
  logic [1:0]           m1;
  logic [32*NUM_CH-1:0] d1, y;
  logic [PW-1:0]        pop, c2;
  logic [32:0]          sum;

  function automatic logic [31:0] act(input logic [31:0] x, input logic [1:0] md);
    logic [7:0] e;
    e = x[30:23];
    if (md == 2'd0) return x;
    if (e == 8'hFF && x[22:0] != '0) return 32'h7FC00000;
    if (e == 8'h00) return '0;
    if (md == 2'd1) return x[31] ? '0 : x;
    if (md == 2'd2) return (!x[31] || e == 8'hFF) ? x :
                           (e > 8'(LEAK_SHIFT)) ? {1'b1, e - 8'(LEAK_SHIFT), x[22:0]} : 32'h80000000;
    return x[31] ? '0 : (x[30:0] > CLAMP_VAL[30:0]) ? CLAMP_VAL : x;
  endfunction

  assign advance  = en & (~out_valid | out_ready);
  assign in_ready = advance;
  assign sum      = 33'(mod_count) + 33'(c2);

  // Stage-2 result and count of lanes that changed (NaN canonicalisation and bypass never count)
  always_comb begin
    y   = '0;
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      y[32*i+:32] = act(d1[32*i+:32], m1);
      pop = pop + PW'(m1 != 2'd0 && !(&d1[32*i+23+:8] && |d1[32*i+:23]) && y[32*i+:32] != d1[32*i+:32]);
    end
  end

  // Two pipeline stages moving together whenever the output slot is free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1        <= 1'b0;
      d1        <= '0;
      m1        <= '0;
      out_valid <= 1'b0;
      output_fc <= '0;
      c2        <= '0;
    end else if (advance) begin
      v1        <= in_valid;
      d1        <= input_fc;
      m1        <= mode;
      out_valid <= v1;
      output_fc <= y;
      c2        <= pop;
    end
  end

  // Saturating debug counter bumped on each output handshake; clear wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mod_count <= '0;
    else if (clr_cnt) mod_count <= '0;
    else if (advance && out_valid) mod_count <= (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  end
endmodule

// File: tb/tb_activation_unit_pipe.sv
// tb_activation_unit_pipe: randomized scoreboard bench for activation_unit_pipe
module tb_activation_unit_pipe;
  localparam int          NC    = 4;
  localparam int          LS    = 3;
  localparam logic [31:0] CLAMP = 32'h40C00000;
  localparam int          CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;

  typedef struct {
    logic [32*NC-1:0] y;
    int               cnt;
  } exp_t;

  logic             clk = 0, reset = 0, en = 1, in_valid = 0, out_ready = 1, clr_cnt = 0;
  logic [1:0]       mode = 0;
  logic [32*NC-1:0] input_fc = '0;
  logic             in_ready, out_valid;
  logic [32*NC-1:0] output_fc;
  logic [CW-1:0]    mod_count;

  exp_t             q[$];
  int               n_cmp = 0, n_bad = 0, mc = 0;
  int               rdy_mode = 0, en_mode = 0, clr_mode = 0;
  bit               l_ok = 0, l_v = 0, l_hold = 0;
  logic [32*NC-1:0] l_out = '0;

  activation_unit_pipe #(.NUM_CH(NC), .LEAK_SHIFT(LS), .CLAMP_VAL(CLAMP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .input_fc(input_fc), .out_valid(out_valid), .out_ready(out_ready), .output_fc(output_fc),
    .clr_cnt(clr_cnt), .mod_count(mod_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [32*NC-1:0] act, input logic [32*NC-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: classify the float, then apply the activation rule for the beat's mode
  function automatic void ref_lane(input logic [31:0] x, input logic [1:0] md, output logic [31:0] y, output bit m);
    int e;
    bit neg;
    e   = int'(x[30:23]);
    neg = x[31];
    y   = x;
    m   = 0;
    if (md == 0) return;
    if (e == 255 && x[22:0] != 0) begin
      y = 32'h7FC00000;
      return;
    end
    if (e == 0) y = 32'h0;
    else if (md == 1) begin
      if (neg) y = 32'h0;
    end else if (md == 2) begin
      if (neg && e != 255) y = (e > LS) ? x - (32'(LS) << 23) : 32'h80000000;
    end else begin
      if (neg) y = 32'h0;
      else if (x[30:0] > CLAMP[30:0]) y = CLAMP;
    end
    m = (y != x);
  endfunction

  function automatic exp_t model(input logic [32*NC-1:0] d, input logic [1:0] md);
    exp_t r;
    logic [31:0] y;
    bit m;
    r.cnt = 0;
    r.y   = '0;
    for (int i = 0; i < NC; i++) begin
      ref_lane(d[32*i+:32], md, y, m);
      r.y[32*i+:32] = y;
      r.cnt += int'(m);
    end
    return r;
  endfunction

  // Handshake-driven scoreboard, counter model, stall/freeze stability checks
  always @(negedge clk) begin
    exp_t e;
    int inc;
    bit hs;
    inc = 0;
    if (!reset) begin
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_output_fc", output_fc, '0);
      chk("rst_mod_count", 128'(mod_count), 128'(0));
      q.delete();
      mc   = 0;
      l_ok = 0;
    end else begin
      if (l_ok && l_hold) begin
        chk("hold_output_fc", output_fc, l_out);
        chk("hold_out_valid", 128'(out_valid), 128'(l_v));
      end
      chk("in_ready", 128'(in_ready), 128'(en & (~out_valid | out_ready)));
      chk("mod_count", 128'(mod_count), 128'(mc));
      hs = en && out_valid && out_ready;
      if (hs) begin
        if (q.size() == 0) chk("unexpected_beat", 128'(1), 128'(0));
        else begin
          e = q.pop_front();
          chk("output_fc", output_fc, e.y);
          inc = e.cnt;
        end
      end
      if (clr_cnt) mc = 0;
      else if (hs) mc = (mc + inc > CMAX) ? CMAX : mc + inc;
      l_ok   = 1;
      l_out  = output_fc;
      l_v    = out_valid;
      l_hold = !en || (out_valid && !out_ready);
      if (in_valid && in_ready) q.push_back(model(input_fc, mode));
    end
  end

  // Side-band controls, re-drawn every cycle according to the current knobs
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    en        = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? ($urandom_range(0, 9) != 0) : 1'b0;
    clr_cnt   = (clr_mode == 0) ? 1'b0 : (clr_mode == 1) ? ($urandom_range(0, 19) == 0) : 1'b1;
  end

  task automatic send(input logic [32*NC-1:0] d, input logic [1:0] md);
    in_valid = 1;
    input_fc = d;
    mode     = md;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("send_timeout", 128'(1), 128'(0));
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_queue_empty", 128'(q.size()), 128'(0));
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] sp[12];
    sp = '{32'h80000000, 32'h00000000, 32'h00400001, 32'h80000005, 32'h7F800000, 32'hFF800000,
           32'h7FC00000, 32'hFF800001, 32'h81800000, 32'h41200000, 32'h40C00000, 32'hC0000000};
    return ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 11)] : $urandom;
  endfunction

  function automatic logic [32*NC-1:0] rnd_beat();
    logic [32*NC-1:0] d;
    for (int i = 0; i < NC; i++) d[32*i+:32] = rnd_word();
    return d;
  endfunction

  initial begin
    in_valid = 1;
    input_fc = rnd_beat();
    mode     = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1;
    in_valid = 0;
    idle(1);
    send({32'h80000000, 32'h80000000, 32'h80000000, 32'h3F800000}, 2'd1);
    send({32'h3F800000, 32'hFF800000, 32'h81000000, 32'hC0000000}, 2'd2);
    send({32'hC1000000, 32'h3F000000, 32'h7F800000, 32'h41200000}, 2'd3);
    send({32'h7F800001, 32'h80000000, 32'hC0000000, 32'h41200000}, 2'd0);
    drain();
    fork
      for (int i = 0; i < 5; i++) send(rnd_beat(), 2'(i % 4));
      begin
        idle(3);
        rdy_mode = 2;
        idle(3);
        rdy_mode = 0;
      end
    join
    drain();
    clr_mode = 2;
    idle(2);
    clr_mode = 0;
    for (int i = 0; i < 5; i++) send({NC{32'h41200000}}, 2'd3);
    drain();
    idle(2);
    clr_mode = 2;
    for (int i = 0; i < 3; i++) send({NC{32'hC0000000}}, 2'd1);
    idle(4);
    clr_mode = 0;
    send({NC{32'h41200000}}, 2'd3);
    en_mode = 2;
    idle(5);
    en_mode = 0;
    drain();
    send(rnd_beat(), 2'd2);
    send(rnd_beat(), 2'd3);
    reset = 0;
    idle(2);
    reset = 1;
    idle(1);
    rdy_mode = 1;
    en_mode  = 1;
    clr_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(rnd_beat(), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 0;
    en_mode  = 0;
    clr_mode = 0;
    drain();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
